branch_predictor: RTL and testbench
===================================

# branch_predictor

IF-stage next-PC predictor and the counterpart of the EX-stage jump resolution logic. Each cycle it predicts the next fetch PC for `current_pc` from a direct-mapped BTB and a 2-bit-counter PHT with gshare indexing. Each resolved JAL, JALR or conditional branch from EX trains the tables, and the block flags a mispredict with the corrected PC. It replaces the static "always PC+4" fetch policy.

## Interface
- `IDX_BITS`, default 5: log2 of the BTB/PHT entry count, which is 32 by default.
- `BHR_BITS`, default 5: global history width; must be ≤ `IDX_BITS`.
- `clk` input, 1 bit: clock. All state changes on the rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `current_pc` input, 32 bits: IF-stage PC.
- `predicted_pc` output, 32 bits: predicted next fetch PC.
- `pred_taken` output, 1 bit: prediction is taken.
- `pred_index` output, `IDX_BITS`: PHT index used for this prediction. The pipeline carries it to EX.
- `update_en` input, 1 bit: a valid (non-bubble) control-flow instruction is in EX this cycle.
- `update_pc` input, 32 bits: PC of the instruction in EX.
- `update_index` input, `IDX_BITS`: `pred_index` carried with that instruction.
- `update_pred_pc` input, 32 bits: `predicted_pc` carried with that instruction.
- `update_uncond` input, 1 bit: the instruction is JAL or JALR.
- `update_taken` input, 1 bit: resolved taken (EX `is_jump`).
- `update_target` input, 32 bits: resolved target (EX `taken_pc`).
- `mispredict` output, 1 bit: flush IF/ID and redirect.
- `correct_pc` output, 32 bits: redirect PC.

## Operation
- **State.**
  - BTB: 2^`IDX_BITS` entries, each holding `valid`, `uncond`, `tag[31:IDX_BITS+2]` and `target[31:0]`.
  - PHT: 2^`IDX_BITS` 2-bit saturating counters.
  - BHR: `BHR_BITS`-bit global history shift register.
- **Index fields.**
  - `bidx` = `pc[IDX_BITS+1:2]`.
  - `pidx` = `bidx` XOR the zero-extended BHR.
- **Lookup (combinational).**
  - `hit` = BTB[`bidx(current_pc)`].valid and its tag equals `current_pc[31:IDX_BITS+2]`.
  - `pred_taken` = `hit` and (entry.`uncond` or PHT[`pidx`][1]).
  - `predicted_pc` = entry.`target` when `pred_taken`, otherwise `current_pc`+4.
  - `pred_index` = `pidx(current_pc)`.
- **Resolution (combinational).**
  - `correct_pc` = `update_target` when `update_taken`, otherwise `update_pc`+4.
  - `mispredict` = `update_en` and (`update_pred_pc` ≠ `correct_pc`).
  - The comparison against the carried `update_pred_pc` also catches a JALR whose target changed.
- **Training (rising edge, when `update_en` is high and `reset` is low).**
  - BTB: when `update_taken`, write BTB[`bidx(update_pc)`] with {valid=1, `uncond`=`update_uncond`, tag, `update_target`}. A not-taken outcome leaves the BTB untouched.
  - PHT: when `update_uncond` is low, PHT[`update_index`] increments on taken (saturating at 3) and decrements on not-taken (saturating at 0). It uses the carried index, never a recomputed one.
  - BHR: when `update_uncond` is low, BHR ← {BHR[`BHR_BITS`-2:0], `update_taken`}. JAL and JALR never touch the PHT or the BHR.
- **Boundary cases.**
  - Simultaneous lookup and write of the same entry: the lookup sees the old value. There is no bypass.
  - Tag mismatch on an aliased index: treated as a miss, so the prediction is PC+4.
  - Counter encoding: 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken.

## Timing
- Prediction has zero latency: combinational from `current_pc` and registered state.
- Training is visible to lookups in the cycle after the update edge.
- `mispredict` and `correct_pc` are combinational in the same cycle as `update_en`. The top level muxes `correct_pc` into the PC with priority over `predicted_pc`.
- **Reset.**
  - At the edge with `reset` high: every BTB valid bit goes to 0, every PHT counter to 01, and the BHR to 0.
  - An `update_en` in that same cycle is ignored, including when reset arrives mid-stream.
- **Outputs while `reset` is high (forced):**
  - `pred_taken`=0 and `predicted_pc`=`current_pc`+4.
  - `mispredict`=0 and `correct_pc`=`update_pc`+4.
- The block has no stall input. The pipeline holds `current_pc` during stalls and the outputs follow it.

## Configuration
- `BP_GSHARE_EN` defined: `pidx` = `bidx` XOR BHR, as described above.
- `BP_GSHARE_EN` undefined (bimodal):
  - `pidx` = `bidx`.
  - The BHR is held at 0 and never shifts.
  - All other behaviour is identical.

## Test plan
All scenarios use the defaults `IDX_BITS`=5 and `BHR_BITS`=5.
- **Reset state.** Pulse reset, then set `current_pc`=0x100 → `predicted_pc`=0x104, `pred_taken`=0, `pred_index`=0.
- **Unconditional entry.** Update with `update_pc`=0x20, `update_uncond`=1, `update_taken`=1, `update_target`=0x80. In the next cycle, `current_pc`=0x20 → `pred_taken`=1, `predicted_pc`=0x80, and the BHR is unchanged.
- **Counter hysteresis (bimodal build).** Use `update_pc`=0x40, `update_target`=0x10, `update_index`=0x10.
  - Two taken updates: counter goes 01→10→11, and `current_pc`=0x40 predicts 0x10.
  - One not-taken update: counter 10, still predicts 0x10.
  - A second not-taken update: counter 01, predicts 0x44.
- **Mispredict detection.**
  - `update_en`=1, `update_pc`=0x40, `update_taken`=1, `update_target`=0x80, `update_pred_pc`=0x44 → `mispredict`=1, `correct_pc`=0x80.
  - `update_en`=1, `update_pc`=0x40, `update_taken`=0, `update_pred_pc`=0x44 → `mispredict`=0.
- **Tag alias.** After training 0x40→0x10 as taken, `current_pc`=0xC0 (same `bidx`, different tag) → `predicted_pc`=0xC4.
- **Gshare and reset mid-update (gshare build).**
  - Three taken conditional updates → BHR=00111.
  - Assert reset together with `update_en`=1 → no BTB write, BHR=0, and every lookup misses afterwards.

Source files
------------

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// IF-stage next-PC predictor. A direct-mapped BTB supplies targets and a table
// of 2-bit saturating counters (PHT) decides taken/not-taken for conditional
// branches. Resolved control-flow instructions from EX train both tables and
// the block raises a mispredict with the redirect PC.
//
// Configuration macro: BP_GSHARE_EN
//   defined   : PHT index = BTB index XOR global history (gshare)
//   undefined : PHT index = BTB index, history held at zero (bimodal)
//
// Ports
//   clk, reset      : clock, synchronous active-high reset
//   current_pc      : IF-stage PC being looked up
//   predicted_pc    : predicted next fetch PC
//   pred_taken      : prediction is taken
//   pred_index      : PHT index used; travels down the pipe to EX
//   update_*        : resolved instruction in EX (pc, carried index and
//                     prediction, JAL/JALR flag, outcome, resolved target)
//   mispredict      : flush and redirect request
//   correct_pc      : redirect PC (resolved target or fall-through)
// -----------------------------------------------------------------------------
module branch_predictor #(
  parameter int IDX_BITS = 5,
  parameter int BHR_BITS = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         current_pc,
  output logic [31:0]         predicted_pc,
  output logic                pred_taken,
  output logic [IDX_BITS-1:0] pred_index,
  input  logic                update_en,
  input  logic [31:0]         update_pc,
  input  logic [IDX_BITS-1:0] update_index,
  input  logic [31:0]         update_pred_pc,
  input  logic                update_uncond,
  input  logic                update_taken,
  input  logic [31:0]         update_target,
  output logic                mispredict,
  output logic [31:0]         correct_pc
);

  localparam int ENTRIES  = 1 << IDX_BITS;
  localparam int TAG_BITS = 30 - IDX_BITS;

`ifdef BP_GSHARE_EN
  localparam bit GSHARE_EN = 1'b1;
`else
  localparam bit GSHARE_EN = 1'b0;
`endif

  // Table state
  logic [ENTRIES-1:0]  btb_valid_q, btb_valid_d;
  logic [ENTRIES-1:0]  btb_uncond_q, btb_uncond_d;
  logic [TAG_BITS-1:0] btb_tag_q    [ENTRIES];
  logic [TAG_BITS-1:0] btb_tag_d    [ENTRIES];
  logic [31:0]         btb_target_q [ENTRIES];
  logic [31:0]         btb_target_d [ENTRIES];
  logic [1:0]          pht_q        [ENTRIES];
  logic [1:0]          pht_d        [ENTRIES];
  logic [BHR_BITS-1:0] bhr_q, bhr_d;

  // Lookup / update helpers
  logic [IDX_BITS-1:0] bhr_ext_s;
  logic [IDX_BITS-1:0] lookup_bidx_s;
  logic [IDX_BITS-1:0] lookup_pidx_s;
  logic [TAG_BITS-1:0] lookup_tag_s;
  logic                hit_s;
  logic [IDX_BITS-1:0] upd_bidx_s;
  logic [TAG_BITS-1:0] upd_tag_s;

  // Index and tag extraction for the lookup and update paths
  always_comb begin
    bhr_ext_s                = '0;
    bhr_ext_s[BHR_BITS-1:0]  = bhr_q;
    lookup_bidx_s            = current_pc[IDX_BITS+1:2];
    lookup_tag_s             = current_pc[31:IDX_BITS+2];
    upd_bidx_s               = update_pc[IDX_BITS+1:2];
    upd_tag_s                = update_pc[31:IDX_BITS+2];
    if (GSHARE_EN) begin
      lookup_pidx_s = lookup_bidx_s ^ bhr_ext_s;
    end else begin
      lookup_pidx_s = lookup_bidx_s;
    end
  end

  // Zero-latency prediction from registered tables; forced to fall-through in reset
  always_comb begin
    hit_s      = btb_valid_q[lookup_bidx_s] && (btb_tag_q[lookup_bidx_s] == lookup_tag_s);
    pred_index = lookup_pidx_s;
    if (!reset && hit_s && (btb_uncond_q[lookup_bidx_s] || pht_q[lookup_pidx_s][1])) begin
      pred_taken   = 1'b1;
      predicted_pc = btb_target_q[lookup_bidx_s];
    end else begin
      pred_taken   = 1'b0;
      predicted_pc = current_pc + 32'd4;
    end
  end

  // Resolution: comparing against the carried prediction also catches JALR target changes
  always_comb begin
    if (!reset && update_taken) begin
      correct_pc = update_target;
    end else begin
      correct_pc = update_pc + 32'd4;
    end
    mispredict = !reset && update_en && (update_pred_pc != correct_pc);
  end

  // Next-state for BTB, PHT and history driven by the resolved instruction
  always_comb begin
    btb_valid_d  = btb_valid_q;
    btb_uncond_d = btb_uncond_q;
    btb_tag_d    = btb_tag_q;
    btb_target_d = btb_target_q;
    pht_d        = pht_q;
    bhr_d        = bhr_q;
    if (update_en) begin
      // Not-taken outcomes never allocate or overwrite a BTB entry
      if (update_taken) begin
        btb_valid_d[upd_bidx_s]  = 1'b1;
        btb_uncond_d[upd_bidx_s] = update_uncond;
        btb_tag_d[upd_bidx_s]    = upd_tag_s;
        btb_target_d[upd_bidx_s] = update_target;
      end else begin
        btb_valid_d[upd_bidx_s]  = btb_valid_q[upd_bidx_s];
      end
      // Only conditional branches train the counters and history; the carried index is used
      if (!update_uncond) begin
        if (update_taken) begin
          if (pht_q[update_index] != 2'b11) begin
            pht_d[update_index] = pht_q[update_index] + 2'd1;
          end else begin
            pht_d[update_index] = pht_q[update_index];
          end
        end else begin
          if (pht_q[update_index] != 2'b00) begin
            pht_d[update_index] = pht_q[update_index] - 2'd1;
          end else begin
            pht_d[update_index] = pht_q[update_index];
          end
        end
        if (GSHARE_EN) begin
          bhr_d = {bhr_q[BHR_BITS-2:0], update_taken};
        end else begin
          bhr_d = bhr_q;
        end
      end else begin
        bhr_d = bhr_q;
      end
    end else begin
      bhr_d = bhr_q;
    end
  end

  // Control state: reset clears valid bits and history, counters start weak not-taken
  always_ff @(posedge clk) begin
    if (reset) begin
      btb_valid_q  <= '0;
      btb_uncond_q <= '0;
      bhr_q        <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        pht_q[i] <= 2'b01;
      end
    end else begin
      btb_valid_q  <= btb_valid_d;
      btb_uncond_q <= btb_uncond_d;
      bhr_q        <= bhr_d;
      pht_q        <= pht_d;
    end
  end

  // BTB payload storage; meaningless while valid is clear, so it is not reset
  always_ff @(posedge clk) begin
    if (reset) begin
      btb_tag_q    <= btb_tag_q;
      btb_target_q <= btb_target_q;
    end else begin
      btb_tag_q    <= btb_tag_d;
      btb_target_q <= btb_target_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
//
// Directed bench for branch_predictor. A table-level model (plain arrays,
// arithmetic indexing) is updated on each rising edge and a compare process
// checks every DUT output against it on each falling edge. Directed steps add
// hand-computed literal expectations for both the DUT and the model.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] current_pc;
  logic [31:0] predicted_pc;
  logic        pred_taken;
  logic [4:0]  pred_index;
  logic        update_en;
  logic [31:0] update_pc;
  logic [4:0]  update_index;
  logic [31:0] update_pred_pc;
  logic        update_uncond;
  logic        update_taken;
  logic [31:0] update_target;
  logic        mispredict;
  logic [31:0] correct_pc;

  always #5 clk = ~clk;

  branch_predictor #(.IDX_BITS(5), .BHR_BITS(5)) dut (
    .clk(clk), .reset(reset), .current_pc(current_pc),
    .predicted_pc(predicted_pc), .pred_taken(pred_taken), .pred_index(pred_index),
    .update_en(update_en), .update_pc(update_pc), .update_index(update_index),
    .update_pred_pc(update_pred_pc), .update_uncond(update_uncond),
    .update_taken(update_taken), .update_target(update_target),
    .mispredict(mispredict), .correct_pc(correct_pc)
  );

`ifdef BP_GSHARE_EN
  localparam bit GS = 1'b1;
`else
  localparam bit GS = 1'b0;
`endif

  // Build-dependent hand-computed expectations
  localparam logic [31:0] HYS_TT  = GS ? 32'h44 : 32'h10;
  localparam logic [31:0] HYS_T1  = GS ? 32'h44 : 32'h10;
  localparam logic [31:0] BHR_3T  = GS ? 32'd7  : 32'd0;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model state
  bit          m_valid  [32];
  bit          m_uncond [32];
  logic [31:0] m_tag    [32];
  logic [31:0] m_target [32];
  int          m_pht    [32];
  int          m_bhr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic int bidx_of(input logic [31:0] pc);
    return int'((pc / 32'd4) % 32'd32);
  endfunction

  function automatic int pidx_of(input logic [31:0] pc);
    return GS ? (bidx_of(pc) ^ m_bhr) : bidx_of(pc);
  endfunction

  function automatic bit model_taken(input logic [31:0] pc);
    int b;
    b = bidx_of(pc);
    return !reset && m_valid[b] && (m_tag[b] == pc / 32'd128) &&
           (m_uncond[b] || (m_pht[pidx_of(pc)] >= 2));
  endfunction

  function automatic logic [31:0] model_pred_pc(input logic [31:0] pc);
    return model_taken(pc) ? m_target[bidx_of(pc)] : pc + 32'd4;
  endfunction

  function automatic logic [31:0] model_correct();
    return (!reset && update_taken) ? update_target : update_pc + 32'd4;
  endfunction

  function automatic bit model_misp();
    return !reset && update_en && (update_pred_pc != model_correct());
  endfunction

  // Model training at each rising edge
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        m_valid[i] <= 1'b0;
        m_pht[i]   <= 1;
      end
      m_bhr <= 0;
    end else if (update_en) begin
      if (update_taken) begin
        m_valid[bidx_of(update_pc)]  <= 1'b1;
        m_uncond[bidx_of(update_pc)] <= update_uncond;
        m_tag[bidx_of(update_pc)]    <= update_pc / 32'd128;
        m_target[bidx_of(update_pc)] <= update_target;
      end
      if (!update_uncond) begin
        if (update_taken)
          m_pht[update_index] <= (m_pht[update_index] == 3) ? 3 : m_pht[update_index] + 1;
        else
          m_pht[update_index] <= (m_pht[update_index] == 0) ? 0 : m_pht[update_index] - 1;
        if (GS)
          m_bhr <= (m_bhr * 2 + (update_taken ? 1 : 0)) % 32;
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_predicted_pc", predicted_pc, model_pred_pc(current_pc));
      check("cyc_pred_taken", {31'd0, pred_taken}, {31'd0, model_taken(current_pc)});
      check("cyc_pred_index", {27'd0, pred_index}, 32'(pidx_of(current_pc)));
      check("cyc_mispredict", {31'd0, mispredict}, {31'd0, model_misp()});
      check("cyc_correct_pc", correct_pc, model_correct());
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_upd(input logic en, input logic [31:0] pc, input logic [4:0] idx,
                         input logic [31:0] ppc, input logic unc, input logic tk,
                         input logic [31:0] tgt);
    update_en = en; update_pc = pc; update_index = idx; update_pred_pc = ppc;
    update_uncond = unc; update_taken = tk; update_target = tgt;
  endtask

  initial begin
    reset = 1'b1;
    current_pc = 32'h0;
    set_upd(1'b0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;

    // Forced outputs during reset; the update in this cycle must be ignored
    current_pc = 32'h40;
    set_upd(1'b1, 32'h10, 5'd4, 32'h0, 1'b1, 1'b1, 32'h300);
    #1;
    check("rst_predicted_pc", predicted_pc, 32'h44);
    check("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
    check("rst_mispredict", {31'd0, mispredict}, 32'd0);
    check("rst_correct_pc", correct_pc, 32'h14);
    cyc();

    // Reset state
    reset = 1'b0;
    set_upd(1'b0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0);
    current_pc = 32'h100;
    #1;
    check("reset_predicted_pc", predicted_pc, 32'h104);
    check("reset_pred_taken", {31'd0, pred_taken}, 32'd0);
    check("reset_pred_index", {27'd0, pred_index}, 32'd0);
    check("reset_ignored_upd", {31'd0, m_valid[4]}, 32'd0);
    check("model_pht_init", 32'(m_pht[5]), 32'd1);
    current_pc = 32'h10;
    #1;
    check("reset_upd_dropped", predicted_pc, 32'h14);

    // Unconditional entry, with same-cycle lookup seeing the old table
    current_pc = 32'h20;
    set_upd(1'b1, 32'h20, 5'd8, 32'h24, 1'b1, 1'b1, 32'h80);
    #1;
    check("jal_mispredict", {31'd0, mispredict}, 32'd1);
    check("jal_correct_pc", correct_pc, 32'h80);
    check("no_bypass_pc", predicted_pc, 32'h24);
    cyc();
    update_en = 1'b0;
    #1;
    check("jal_pred_taken", {31'd0, pred_taken}, 32'd1);
    check("jal_predicted_pc", predicted_pc, 32'h80);
    check("jal_bhr_unchanged", {27'd0, pred_index}, 32'd8);

    // Counter hysteresis on 0x40 -> 0x10, carried index 0x10
    current_pc = 32'h40;
    set_upd(1'b1, 32'h40, 5'h10, 32'h44, 1'b0, 1'b1, 32'h10);
    cyc();
    cyc();
    update_en = 1'b0;
    #1;
    check("hys_tt_pc", predicted_pc, HYS_TT);
    check("hys_tt_ctr", 32'(m_pht[16]), 32'd3);
    set_upd(1'b1, 32'h40, 5'h10, 32'h10, 1'b0, 1'b0, 32'h10);
    cyc();
    update_en = 1'b0;
    #1;
    check("hys_t1_pc", predicted_pc, HYS_T1);
    check("hys_t1_ctr", 32'(m_pht[16]), 32'd2);
    update_en = 1'b1;
    cyc();
    update_en = 1'b0;
    #1;
    check("hys_nt_pc", predicted_pc, 32'h44);
    check("hys_nt_ctr", 32'(m_pht[16]), 32'd1);

    // Mispredict detection
    set_upd(1'b1, 32'h40, 5'h10, 32'h44, 1'b0, 1'b1, 32'h80);
    #1;
    check("misp_taken", {31'd0, mispredict}, 32'd1);
    check("misp_taken_pc", correct_pc, 32'h80);
    set_upd(1'b1, 32'h40, 5'h10, 32'h44, 1'b0, 1'b0, 32'h80);
    #1;
    check("misp_nt_ok", {31'd0, mispredict}, 32'd0);
    check("misp_nt_pc", correct_pc, 32'h44);
    cyc();

    // Tag alias: 0x40 and 0xC0 share an index but not a tag
    set_upd(1'b1, 32'h40, 5'h10, 32'h44, 1'b1, 1'b1, 32'h10);
    cyc();
    update_en = 1'b0;
    current_pc = 32'h40;
    #1;
    check("alias_owner_pc", predicted_pc, 32'h10);
    current_pc = 32'hC0;
    #1;
    check("alias_miss_pc", predicted_pc, 32'hC4);
    check("alias_miss_taken", {31'd0, pred_taken}, 32'd0);

    // History build-up, then reset arriving with an update
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    set_upd(1'b1, 32'h40, 5'd0, 32'h44, 1'b0, 1'b1, 32'h10);
    repeat (3) cyc();
    update_en = 1'b0;
    current_pc = 32'h100;
    #1;
    check("gshare_bhr_idx", {27'd0, pred_index}, BHR_3T);
    check("model_bhr", 32'(m_bhr), BHR_3T);
    reset = 1'b1;
    current_pc = 32'h40;
    set_upd(1'b1, 32'h60, 5'd0, 32'h64, 1'b1, 1'b1, 32'h200);
    #1;
    check("rstmid_predicted", predicted_pc, 32'h44);
    check("rstmid_mispredict", {31'd0, mispredict}, 32'd0);
    check("rstmid_correct_pc", correct_pc, 32'h64);
    cyc();
    reset = 1'b0;
    update_en = 1'b0;
    current_pc = 32'h60;
    #1;
    check("rstmid_no_write", predicted_pc, 32'h64);
    current_pc = 32'h40;
    #1;
    check("rstmid_miss_40", predicted_pc, 32'h44);
    current_pc = 32'h100;
    #1;
    check("rstmid_bhr_zero", {27'd0, pred_index}, 32'd0);
    current_pc = 32'h20;
    #1;
    check("rstmid_miss_20", predicted_pc, 32'h24);
    repeat (2) cyc();
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
